// File: rtl/mux_32to1_pkg.sv
// Shared constants and data-word type for the 32-entry register file with 32:1 read mux.
// Optional output register is controlled by the MUX_OUT_REG_EN macro in mux_32to1.
package mux_32to1_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int SEL_W    = 5;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/mux_32to1_register.sv
// Single WIDTH-bit storage register: async clear to 0, loads d when enable is high.
// Latency: q updates on the rising edge after enable; no backpressure (always accepts).
// Backpressure: none.
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mux_32to1.sv
// 32-entry register file with write decode and 32:1 read mux; optional output register (MUX_OUT_REG_EN).
// Latency: write visible after the edge; read 0 cycles (1 cycle with MUX_OUT_REG_EN).
// Backpressure: none; every write and read is accepted every cycle.
module mux_32to1
    import mux_32to1_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = NUM_REGS
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0] select,
    output logic [WIDTH-1:0] data_out
);

    logic [DEPTH-1:0] reg_en;
    logic [WIDTH-1:0] reg_q [DEPTH];
    logic [WIDTH-1:0] mux_dat;

    // One-hot write decode: exactly one register loads when wr_en is high.
    always_comb begin
        reg_en = '0;
        if (wr_en) begin
            reg_en[wr_sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_regs
        register #(
            .WIDTH (WIDTH)
        ) u_register (
            .clock   (clock),
            .reset_n (reset_n),
            .enable  (reg_en[i]),
            .d       (data_in),
            .q       (reg_q[i])
        );
    end

    // All 32 select codes address a real register, so there is no default gap.
    always_comb begin
        mux_dat = reg_q[select];
    end

`ifdef MUX_OUT_REG_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
        end else begin
            data_out <= mux_dat;
        end
    end
`else
    assign data_out = mux_dat;
`endif

endmodule

// File: tb/tb_mux_32to1.sv
// Self-checking bench for mux_32to1: vector tables, directed corner sequences and a randomized run
// against an array model of the register file; honours MUX_OUT_REG_EN for read latency.
module tb_mux_32to1;

    logic        clock;
    logic        reset_n;
    logic        wr_en;
    logic [4:0]  wr_sel;
    logic [31:0] data_in;
    logic [4:0]  select;
    logic [31:0] data_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [32];

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [32];

    mux_32to1 #(
        .WIDTH (32),
        .DEPTH (32)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .data_in  (data_in),
        .select   (select),
        .data_out (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
        end
    endtask

    // Drive select at a falling edge and compare once the output is settled.
    task automatic read_chk(input logic [4:0] sel, input logic [31:0] exp, input string name);
        @(negedge clock);
        select = sel;
`ifdef MUX_OUT_REG_EN
        @(posedge clock);
`endif
        #1;
        check($sformatf("%s[%0d]", name, sel), data_out, exp);
    endtask

    task automatic do_write(input logic [4:0] sel, input logic [31:0] dat);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_sel  = sel;
        data_in = dat;
        @(negedge clock);
        wr_en   = 1'b0;
        if (reset_n) model[sel] = dat;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
    endtask

    task automatic sweep_model(input string name);
        for (int k = 0; k < 32; k++) read_chk(k[4:0], model[k], name);
    endtask

    initial begin
        logic [31:0] reg_exp;
        logic [31:0] reg_exp_nxt;
        logic        r_wr;
        logic [4:0]  r_wsel;
        logic [4:0]  r_sel;
        logic [31:0] r_dat;

        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 5'd0;
        data_in = 32'h0;
        select  = 5'd0;
        clear_model();

        // Reset sweep: every select reads zero while reset is held.
        for (int k = 0; k < 32; k++) read_chk(k[4:0], 32'h0, "reset_sweep");

        // Write attempted during reset is lost.
        do_write(5'd3, 32'hDEADBEEF);
        reset_n = 1'b1;
        read_chk(5'd3, 32'h0, "write_in_reset");

        // Load-and-sweep table.
        tbl[0] = '{5'd0, 32'h0000000F};
        tbl[1] = '{5'd1, 32'h0000000A};
        tbl[2] = '{5'd2, 32'h00000000};
        tbl[3] = '{5'd3, 32'h00000001};
        tbl[4] = '{5'd4, 32'h00000002};
        tbl[5] = '{5'd5, 32'h0000F000};
        tbl[6] = '{5'd6, 32'h00000004};
        for (int k = 7; k < 32; k++) tbl[k] = '{k[4:0], 32'h0};
        for (int k = 0; k < 7; k++) do_write(tbl[k].sel, tbl[k].exp);
        for (int k = 0; k < 32; k++) read_chk(tbl[k].sel, tbl[k].exp, "load_sweep");

        // Read during write to the selected register: old value before the edge, new after.
        read_chk(5'd5, 32'h0000F000, "rdw_setup");
        @(negedge clock);
        wr_en   = 1'b1;
        wr_sel  = 5'd5;
        data_in = 32'h12345678;
        #1;
        check("rdw_before_edge", data_out, 32'h0000F000);
        @(posedge clock);
`ifdef MUX_OUT_REG_EN
        #1;
        check("rdw_reg_old", data_out, 32'h0000F000);
        @(posedge clock);
`endif
        #1;
        check("rdw_after_edge", data_out, 32'h12345678);
        @(negedge clock);
        wr_en = 1'b0;
        model[5] = 32'h12345678;

        // Write disabled with all-ones data for four edges.
        @(negedge clock);
        data_in = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            wr_sel = k[4:0];
            @(negedge clock);
        end
        sweep_model("wr_disabled");

        // Walking one across all registers.
        for (int k = 0; k < 32; k++) do_write(k[4:0], 32'h1 << k);
        for (int k = 0; k < 32; k++) read_chk(k[4:0], 32'h1 << k, "walk_one");

        // Mid-operation reset between edges: output drops to zero at once.
        read_chk(5'd31, 32'h80000000, "pre_reset");
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_out", data_out, 32'h0);
        clear_model();
        for (int k = 0; k < 32; k += 7) read_chk(k[4:0], 32'h0, "in_reset");

        // Release at a falling edge; a write on the very next rising edge must land.
        @(negedge clock);
        reset_n = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 5'd9;
        data_in = 32'hA5A5_0009;
        @(negedge clock);
        wr_en = 1'b0;
        model[9] = 32'hA5A5_0009;
        read_chk(5'd9, 32'hA5A5_0009, "first_edge_write");

        // Randomized traffic against the array model.
        @(negedge clock);
        select = 5'd0;
        @(posedge clock);
        reg_exp = model[0];
        for (int it = 0; it < 400; it++) begin
            @(negedge clock);
            r_wr   = ($urandom_range(0, 3) != 0);
            r_wsel = 5'($urandom_range(0, 31));
            r_sel  = ($urandom_range(0, 3) == 0) ? r_wsel : 5'($urandom_range(0, 31));
            r_dat  = $urandom;
            wr_en   = r_wr;
            wr_sel  = r_wsel;
            data_in = r_dat;
            select  = r_sel;
            #1;
`ifdef MUX_OUT_REG_EN
            check("rand_read", data_out, reg_exp);
`else
            check("rand_read", data_out, model[r_sel]);
`endif
            reg_exp_nxt = model[r_sel];
            if (r_wr) model[r_wsel] = r_dat;
            @(posedge clock);
            reg_exp = reg_exp_nxt;
        end
        @(negedge clock);
        wr_en = 1'b0;
        sweep_model("rand_final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
